register_file_sb: RTL
=====================

# register_file_sb

Parametrised integer register file with a built-in write-pending scoreboard for the RISC-V core. It holds `no_of_registers` architectural registers, with `read_ports` combinational read ports and one synchronous write port. x0 is hardwired to zero, and the stack pointer resets to the top of data memory. Per-register busy bits let decode detect RAW hazards against multi-cycle producers (loads, multiply/divide). It sits between decode (read/issue) and writeback (write/clear).

## Interface
Derived constant: AW = $clog2(no_of_registers).

Parameters:
- `bits`, 32, register width
- `no_of_registers`, 32, number of registers including x0
- `read_ports`, 2, number of independent read ports
- `addr_width_DMEM`, 10, data-memory address width; sets the SP reset value
- `sp_index`, 2, index of the stack-pointer register

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock
- `async_reset_n` input 1: asynchronous, active-low reset
- `rs_addr` input read_ports*AW: read addresses; port i occupies bits [i*AW +: AW]
- `rs_data` output read_ports*bits: read data, port i at [i*bits +: bits]
- `rs_busy` output read_ports: port i source still pending
- `hazard` output 1: OR of `rs_busy`
- `we` input 1: writeback enable
- `rd_addr` input AW: writeback address
- `rd_data` input bits: writeback data
- `issue_en` input 1: mark a destination register as pending
- `issue_addr` input AW: destination being issued
- `flush` input 1: clear all busy bits (pipeline flush)

## Operation
- Reset (`async_reset_n` = 0) acts immediately, independent of `clk`:
  - all registers go to 0, except register `sp_index`, which goes to 2**addr_width_DMEM;
  - all busy bits go to 0;
  - outputs follow combinationally from these values.
- Write: at the rising edge, if `we` and `rd_addr` != 0 and `rd_addr` < `no_of_registers`, then reg[rd_addr] <= `rd_data`. Otherwise no change.
- Read, per port i, combinational, in this priority:
  1. address 0 or out of range → 0;
  2. `we` && `rd_addr` == address → `rd_data` (write-through bypass);
  3. otherwise → reg[address].
- Scoreboard, per register at the rising edge, in this priority:
  1. `flush` → busy <= 0 for all registers;
  2. `issue_en` && `issue_addr` == n → busy[n] <= 1;
  3. `we` && `rd_addr` == n → busy[n] <= 0.
- Scoreboard rules:
  - Issue and writeback to the same register in the same cycle leave it busy (the newer producer wins).
  - Issue to x0 or to an out-of-range address is ignored; busy[0] is always 0.
- `rs_busy[i]` = busy[addr_i] && !(`we` && `rd_addr` == addr_i). Bypassed data is never reported as busy.
- `hazard` = |`rs_busy`.
- Non-power-of-two `no_of_registers`: out-of-range addresses read 0, are never busy, and ignore writes and issues.

## Timing
- Write latency: 1 cycle. Data written at edge k is visible from `reg` after edge k. The same value is visible during the cycle before edge k via the bypass.
- Read latency: 0 cycles. `rs_data`, `rs_busy` and `hazard` are purely combinational from addresses, `we`, `rd_addr`, `rd_data` and state.
- Busy set by issue at edge k appears on `rs_busy` after edge k.
- Busy is cleared for hazard purposes in the same cycle as the matching writeback, through the bypass term.
- Reset asserted mid-cycle forces the reset values at once. After deassertion, the first state update happens at the next rising edge.
- No output is registered; there is no internal pipeline.

## Test plan
- Reset, then read x2 and x5 (defaults): x2 reads 0x00000400 (`addr_width_DMEM` = 10), x5 reads 0, `hazard` = 0.
- Write x5 = 0xDEADBEEF with x5 on port 0 in the same cycle: port 0 reads 0xDEADBEEF before the edge via bypass, and still 0xDEADBEEF after the edge from storage. Then write x0 = 0x1234: x0 still reads 0.
- Issue x7, next cycle read x7 on port 1: `rs_busy` = 2'b10 and `hazard` = 1. Write back x7 = 0x55: in that same cycle `rs_busy` = 0 and `rs_data` port 1 = 0x55. After the edge, busy[7] = 0.
- Issue x9 and write back x9 in the same cycle: x9 remains busy after the edge. Then assert `flush` together with issue x9: busy[9] = 0.
- Assert `async_reset_n` low between clock edges with x3 = 0xAA and x4 busy: x3 reads 0 and `hazard` = 0 immediately, before any clock edge.
- `no_of_registers` = 24: read address 30 returns 0; a write to 30 and an issue of 30 have no effect; reads of x1–x23 are unchanged.

Source files
------------

// File: rtl/register_file_sb.sv
// Integer register file with per-register write-pending scoreboard.
// Combinational reads with write-through bypass; one synchronous write port.
module register_file_sb #(
   parameter int bits            = 32,
   parameter int no_of_registers = 32,
   parameter int read_ports      = 2,
   parameter int addr_width_DMEM = 10,
   parameter int sp_index        = 2,
   localparam int AW = $clog2(no_of_registers)
) (
   input  logic                       clk,
   input  logic                       async_reset_n,
   input  logic [read_ports*AW-1:0]   rs_addr,
   output logic [read_ports*bits-1:0] rs_data,
   output logic [read_ports-1:0]      rs_busy,
   output logic                       hazard,
   input  logic                       we,
   input  logic [AW-1:0]              rd_addr,
   input  logic [bits-1:0]            rd_data,
   input  logic                       issue_en,
   input  logic [AW-1:0]              issue_addr,
   input  logic                       flush
);

   localparam int NSLOT = 2**AW;
   localparam logic [bits-1:0] SP_RST =
      bits'(64'd1 << addr_width_DMEM);

   logic [bits-1:0]            regs_q [1:no_of_registers-1];
   logic [bits-1:0]            regs_d [1:no_of_registers-1];
   logic [no_of_registers-1:1] busy_q;
   logic [no_of_registers-1:1] busy_d;

   logic [bits-1:0]  rf [NSLOT];
   logic [NSLOT-1:0] valid;
   logic [NSLOT-1:0] busy_v;

   // Next state: writeback clears busy, issue re-marks it, flush wins.
   always_comb begin
      for (int n = 1; n < no_of_registers; n++) begin
         regs_d[n] = regs_q[n];
         busy_d[n] = busy_q[n];
         if (we && rd_addr == AW'(n)) begin
            regs_d[n] = rd_data;
            busy_d[n] = 1'b0;
         end
         if (issue_en && issue_addr == AW'(n)) begin
            busy_d[n] = 1'b1;
         end
         if (flush) begin
            busy_d[n] = 1'b0;
         end
      end
   end

   // Storage and scoreboard; SP resets to the top of data memory.
   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         for (int n = 1; n < no_of_registers; n++) begin
            regs_q[n] <= (n == sp_index) ? SP_RST : '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   // Expand to the full address space; x0 and unused slots read as empty.
   always_comb begin
      for (int n = 0; n < NSLOT; n++) begin
         valid[n]  = 1'b0;
         rf[n]     = '0;
         busy_v[n] = 1'b0;
      end
      for (int n = 1; n < no_of_registers; n++) begin
         valid[n]  = 1'b1;
         rf[n]     = regs_q[n];
         busy_v[n] = busy_q[n];
      end
   end

   // Read ports: zero for x0/out-of-range, then bypass, then storage.
   always_comb begin
      logic [AW-1:0] a;
      logic          byp;
      a       = '0;
      byp     = 1'b0;
      rs_data = '0;
      rs_busy = '0;
      for (int i = 0; i < read_ports; i++) begin
         a   = rs_addr[i*AW +: AW];
         byp = we && (rd_addr == a);
         rs_data[i*bits +: bits] =
            !valid[a] ? '0 : (byp ? rd_data : rf[a]);
         rs_busy[i] = valid[a] && busy_v[a] && !byp;
      end
   end

   assign hazard = |rs_busy;

endmodule
